// File: rtl/npc_mc_pkg.sv
// rtl/npc_mc_pkg.sv - shared state, error-cause and reset constants for the NPC multi-cycle controller
package npc_mc_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } npc_mc_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_IFETCH  = 2'b01;
  localparam logic [1:0] ERR_DMEM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/npc_wait_timer.sv
// rtl/npc_wait_timer.sv - per-state wait counter; expired flags the last allowed cycle of a wait
module npc_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/npc_mc_ctrl.sv
// rtl/npc_mc_ctrl.sv - multi-cycle fetch/exec/mem/wb sequencer owning the PC
// Optional wait-state timeout halting is built when NPC_MC_TIMEOUT_EN is defined.
module npc_mc_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(npc_mc_pkg::RESET_PC_DEFAULT),
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_ebreak,
  input  logic [XLEN-1:0] npc,
  output logic            dmem_req_valid,
  output logic            dmem_req_we,
  input  logic            dmem_req_ready,
  input  logic            dmem_resp_valid,
  input  logic            dmem_resp_err,
  output logic            rf_we_en,
  output logic            commit,
  output logic            halt,
  output logic [1:0]      err_cause
);
  import npc_mc_pkg::*;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..65535");
  end

  npc_mc_state_t   state, state_n;
  logic [1:0]      err_q, err_n;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            is_store_q;

`ifdef NPC_MC_TIMEOUT_EN
  logic tmr_expired;
  logic waiting;

  assign waiting = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                   (state == MEM_REQ)   || (state == MEM_WAIT);

  npc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .enable  (waiting),
    .expired (tmr_expired)
  );
`endif

  always_comb begin
    state_n = state;
    err_n   = err_q;
    case (state)
      FETCH_REQ:  if (imem_req_ready) state_n = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_n = HALT;
            err_n   = ERR_IFETCH;
          end else begin
            state_n = EXEC;
          end
        end
      end
      EXEC:       state_n = (dec_is_load || dec_is_store) ? MEM_REQ : WB;
      MEM_REQ:    if (dmem_req_ready) state_n = MEM_WAIT;
      MEM_WAIT: begin
        if (dmem_resp_valid) begin
          if (dmem_resp_err) begin
            state_n = HALT;
            err_n   = ERR_DMEM;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        if (dec_ebreak) begin
          state_n = HALT;
          err_n   = ERR_NONE;
        end else begin
          state_n = FETCH_REQ;
        end
      end
      default:    state_n = HALT;
    endcase
`ifdef NPC_MC_TIMEOUT_EN
    // A wait state that has used its last cycle without its completing event gives up.
    if (waiting && tmr_expired && (state_n == state)) begin
      state_n = HALT;
      err_n   = ERR_TIMEOUT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH_REQ;
      err_q      <= ERR_NONE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      is_store_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (state == FETCH_WAIT && imem_resp_valid && !imem_resp_err) inst_q <= imem_resp_data;
      if (state == EXEC) is_store_q <= dec_is_store;
      if (state == WB && !dec_ebreak) pc_q <= npc;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign imem_req_valid = (state == FETCH_REQ);
  assign dmem_req_valid = (state == MEM_REQ);
  assign dmem_req_we    = (state == MEM_REQ) && is_store_q;
  assign rf_we_en       = (state == WB);
  assign commit         = (state == WB);
  assign halt           = (state == HALT);
  assign err_cause      = err_q;

endmodule

// File: tb/tb_npc_mc_ctrl.sv
// tb/tb_npc_mc_ctrl.sv - randomized self-checking bench for npc_mc_ctrl against a timeline model
module tb_npc_mc_ctrl;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam int          TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc, inst, imem_addr, imem_resp_data, npc;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_err;
  logic        dec_is_load, dec_is_store, dec_ebreak;
  logic        dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_resp_valid, dmem_resp_err;
  logic        rf_we_en, commit, halt;
  logic [1:0]  err_cause;

  npc_mc_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_ebreak(dec_ebreak), .npc(npc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_err(dmem_resp_err),
    .rf_we_en(rf_we_en), .commit(commit), .halt(halt), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc, m_inst;

  typedef struct packed {
    logic irdy, ivld, ierr, ifw, drdy, dvld, derr;
  } cyc_t;

  task automatic idle();
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_err = 0; imem_resp_data = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_err = 0;
    dec_is_load = 0; dec_is_store = 0; dec_ebreak = 0; npc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1;
    m_pc = RPC;
    m_inst = 32'h0000_0013;
  endtask

  // Expected instruction length in cycles, from the phase rules alone.
  function automatic int exp_len(input int ird, input int ipd, input logic ie, input logic mem,
                                 input int drd, input int dpd, input logic de);
    int n;
    n = ird + 1 + ipd + 1;
    if (ie) return n;
    n += 1;
    if (mem) begin
      n += drd + 1 + dpd + 1;
      if (de) return n;
    end
    return n + 1;
  endfunction

  // Plays one instruction's memory/decoder timeline; responses offered during request
  // phases are noise the controller must ignore.
  task automatic run_instr(input int ird, input int ipd, input logic [31:0] idata, input logic ie,
                           input logic ld, input logic st, input logic eb, input logic [31:0] nxt,
                           input int drd, input int dpd, input logic de, input int stop,
                           output int n_commit, output int commit_at,
                           output logic addr_ok, output logic we_ok);
    cyc_t tl[$];
    cyc_t c;
    int   len;
    for (int i = 0; i <= ird; i++) begin
      c = '0; c.irdy = (i == ird);
      c.ivld = 1'($urandom_range(0, 1)); c.ierr = 1'($urandom_range(0, 1));
      tl.push_back(c);
    end
    for (int i = 0; i <= ipd; i++) begin
      c = '0; c.ifw = 1; c.ivld = (i == ipd); c.ierr = (i == ipd) && ie;
      tl.push_back(c);
    end
    if (!ie) begin
      tl.push_back('0);
      if (ld || st) begin
        for (int i = 0; i <= drd; i++) begin
          c = '0; c.drdy = (i == drd);
          c.dvld = 1'($urandom_range(0, 1)); c.derr = 1'($urandom_range(0, 1));
          tl.push_back(c);
        end
        for (int i = 0; i <= dpd; i++) begin
          c = '0; c.dvld = (i == dpd); c.derr = (i == dpd) && de;
          tl.push_back(c);
        end
      end
      if (!((ld || st) && de)) tl.push_back('0);
    end
    len = tl.size();
    if (stop >= 0 && stop < len) len = stop;
    n_commit = 0; commit_at = -1; addr_ok = 1; we_ok = 1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (commit) begin n_commit++; commit_at = k; end
      if (imem_addr !== m_pc) addr_ok = 0;
      if (dmem_req_valid && (dmem_req_we !== st)) we_ok = 0;
      dec_is_load = ld; dec_is_store = st; dec_ebreak = eb; npc = nxt;
      imem_req_ready  = tl[k].irdy;
      imem_resp_valid = tl[k].ivld;
      imem_resp_err   = tl[k].ierr;
      imem_resp_data  = tl[k].ifw ? idata : $urandom;
      dmem_req_ready  = tl[k].drdy;
      dmem_resp_valid = tl[k].dvld;
      dmem_resp_err   = tl[k].derr;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
    n_checks++; if (inst !== 32'h13) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", inst); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_ireq: got %b expected 1", imem_req_valid); end
    n_checks++;
    if ({dmem_req_valid, rf_we_en, commit, halt, err_cause} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000", {dmem_req_valid, rf_we_en, commit, halt, err_cause});
    end
  endtask

  task automatic test_addi();
    int nc, ca; logic aok, wok;
    do_reset();
    run_instr(0, 0, 32'h0010_0093, 0, 0, 0, 0, 32'h8000_0004, 0, 0, 0, -1, nc, ca, aok, wok);
    n_checks++; if (ca !== 3) begin n_fail++; $display("FAIL addi_commit_cycle: got %0d expected 3", ca); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL addi_commit_count: got %0d expected 1", nc); end
    m_pc = 32'h8000_0004;
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL addi_pc: got %h expected %h", pc, m_pc); end
    n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL addi_imem_addr: got %h expected %h", imem_addr, m_pc); end
    n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL addi_inst: got %h expected 00100093", inst); end
  endtask

  task automatic test_stall_ebreak();
    int nc, ca, bad; logic aok, wok;
    do_reset();
    run_instr(3, 0, 32'h0010_0073, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, -1, nc, ca, aok, wok);
    n_checks++; if (aok !== 1'b1) begin n_fail++; $display("FAIL ebreak_addr_stable: got %b expected 1", aok); end
    n_checks++; if (nc !== 1 || ca !== exp_len(3, 0, 0, 0, 0, 0, 0) - 1) begin
      n_fail++; $display("FAIL ebreak_commit: got count %0d at %0d expected 1 at %0d", nc, ca, exp_len(3, 0, 0, 0, 0, 0, 0) - 1);
    end
    n_checks++; if ({halt, err_cause} !== 3'b100) begin n_fail++; $display("FAIL ebreak_halt: got %b expected 100", {halt, err_cause}); end
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL ebreak_pc: got %h expected %h", pc, m_pc); end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      imem_req_ready = 1'($urandom); imem_resp_valid = 1'($urandom); dmem_req_ready = 1'($urandom);
      dmem_resp_valid = 1'($urandom); npc = $urandom;
      @(negedge clk);
      if (!halt || commit || rf_we_en || imem_req_valid || dmem_req_valid || pc !== m_pc || inst !== 32'h0010_0073) bad++;
    end
    idle();
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_load_delay();
    int nc, ca; logic aok, wok;
    do_reset();
    run_instr(0, 0, 32'h0000_2103, 0, 1, 0, 0, 32'h8000_0004, 2, 5, 0, -1, nc, ca, aok, wok);
    n_checks++; if (wok !== 1'b1) begin n_fail++; $display("FAIL load_we: got ok=%b expected 1", wok); end
    n_checks++; if (nc !== 1 || ca !== 12) begin n_fail++; $display("FAIL load_latency: got count %0d at %0d expected 1 at 12", nc, ca); end
    m_pc = 32'h8000_0004;
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL load_pc: got %h expected %h", pc, m_pc); end
  endtask

  task automatic test_store_err();
    int nc, ca; logic aok, wok;
    do_reset();
    run_instr(1, 1, 32'h0020_2023, 0, 0, 1, 0, 32'h9000_0000, 1, 2, 1, -1, nc, ca, aok, wok);
    n_checks++; if (wok !== 1'b1) begin n_fail++; $display("FAIL store_we: got ok=%b expected 1", wok); end
    n_checks++; if (nc !== 0) begin n_fail++; $display("FAIL store_err_commit: got %0d expected 0", nc); end
    n_checks++; if ({halt, err_cause} !== 3'b110) begin n_fail++; $display("FAIL store_err_halt: got %b expected 110", {halt, err_cause}); end
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL store_err_pc: got %h expected %h", pc, m_pc); end
  endtask

  task automatic test_fetch_err();
    int nc, ca; logic aok, wok; logic [31:0] d, n;
    do_reset();
    d = $urandom; n = $urandom;
    run_instr(0, 2, d, 0, 0, 0, 0, n, 0, 0, 0, -1, nc, ca, aok, wok);
    m_pc = n; m_inst = d;
    run_instr(2, 1, $urandom, 1, 0, 0, 0, $urandom, 0, 0, 0, -1, nc, ca, aok, wok);
    n_checks++; if (nc !== 0) begin n_fail++; $display("FAIL fetch_err_commit: got %0d expected 0", nc); end
    n_checks++; if ({halt, err_cause} !== 3'b101) begin n_fail++; $display("FAIL fetch_err_halt: got %b expected 101", {halt, err_cause}); end
    n_checks++; if (pc !== m_pc || inst !== m_inst) begin
      n_fail++; $display("FAIL fetch_err_hold: got pc %h inst %h expected %h %h", pc, inst, m_pc, m_inst);
    end
  endtask

  task automatic test_back_to_back();
    int nc, ca, ird, ipd, drd, dpd, kind; logic aok, wok; logic [31:0] d, n;
    do_reset();
    for (int t = 0; t < 16; t++) begin
      ird = $urandom_range(0, 5); ipd = $urandom_range(0, 5);
      drd = $urandom_range(0, 5); dpd = $urandom_range(0, 5);
      kind = $urandom_range(0, 2); d = $urandom; n = $urandom;
      run_instr(ird, ipd, d, 0, kind == 1, kind == 2, 0, n, drd, dpd, 0, -1, nc, ca, aok, wok);
      n_checks++;
      if (nc !== 1 || ca !== exp_len(ird, ipd, 0, kind != 0, drd, dpd, 0) - 1) begin
        n_fail++; $display("FAIL b2b_commit[%0d]: got count %0d at %0d expected 1 at %0d", t, nc, ca,
                           exp_len(ird, ipd, 0, kind != 0, drd, dpd, 0) - 1);
      end
      n_checks++; if (aok !== 1'b1 || wok !== 1'b1) begin n_fail++; $display("FAIL b2b_addr_we[%0d]: got %b%b expected 11", t, aok, wok); end
      m_pc = n; m_inst = d;
      n_checks++;
      if (pc !== m_pc || inst !== m_inst || halt !== 1'b0) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got pc %h inst %h halt %b expected %h %h 0", t, pc, inst, halt, m_pc, m_inst);
      end
    end
  endtask

  task automatic test_timeout();
    int first_halt;
    first_halt = -1;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (halt && first_halt < 0) first_halt = k;
    end
`ifdef NPC_MC_TIMEOUT_EN
    n_checks++; if (first_halt !== TMO) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", first_halt, TMO); end
    n_checks++; if (err_cause !== 2'b11 || pc !== RPC) begin
      n_fail++; $display("FAIL timeout_cause: got %b pc %h expected 11 pc %h", err_cause, pc, RPC);
    end
`else
    n_checks++; if (first_halt !== -1) begin n_fail++; $display("FAIL no_timeout_halt: got %0d expected -1", first_halt); end
    n_checks++; if (imem_req_valid !== 1'b1 || err_cause !== 2'b00) begin
      n_fail++; $display("FAIL no_timeout_wait: got ireq %b cause %b expected 1 00", imem_req_valid, err_cause);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int nc, ca; logic aok, wok; logic [31:0] n;
    do_reset();
    n = $urandom | 32'h1;
    run_instr(0, 0, $urandom, 0, 0, 0, 0, n, 0, 0, 0, -1, nc, ca, aok, wok);
    m_pc = n;
    run_instr(0, 0, $urandom, 0, 1, 0, 0, $urandom, 0, 5, 0, 6, nc, ca, aok, wok);
    n_checks++; if (nc !== 0 || pc !== m_pc) begin n_fail++; $display("FAIL mid_pre: got count %0d pc %h expected 0 %h", nc, pc, m_pc); end
    #2 rst = 0;
    #1;
    n_checks++; if (pc !== RPC) begin n_fail++; $display("FAIL mid_reset_pc: got %h expected %h", pc, RPC); end
    n_checks++;
    if ({imem_req_valid, dmem_req_valid, commit, halt} !== 4'b1000) begin
      n_fail++; $display("FAIL mid_reset_state: got %b expected 1000", {imem_req_valid, dmem_req_valid, commit, halt});
    end
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle();
    test_reset();
    test_addi();
    test_stall_ebreak();
    test_load_delay();
    test_store_err();
    test_fetch_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
